mcu_420_scheduler: RTL and testbench

- Sequences one 4:2:0 MCU (4 Y blocks, 1 Cb, 1 Cr) through the combinational chroma supersampler `supersample_8x8`.
- Buffers the four Y blocks and the two upsampled chroma planes.
- Emits four aligned Y/Cb/Cr 8x8 block triples, one per quadrant, to the colour-conversion stage over a valid/ready handshake.
- Sits between IDCT output and colour conversion.

---
 rtl/mcu_420_scheduler.sv | 154 +++++++++++++++
 tb/tb_mcu_420_scheduler.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_420_scheduler.sv
// Purpose: sequences one 4:2:0 MCU (4 Y, Cb, Cr) through the chroma supersampler and emits four Y/Cb/Cr quadrant triples.
// Latency: first triple is valid the cycle after Cr acceptance; 6 input cycles + 4 output cycles per MCU, no overlap.
// Backpressure: in_ready drops while emitting; triples are held stable until out_ready. Option macro GRAYSCALE_EN adds gray_mode.
module mcu_420_scheduler #(
    parameter int SW  = 9,
    parameter int CHW = $clog2(3)
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         in_valid,
    input  logic [CHW-1:0]               in_ch,
    input  logic [7:0][7:0][SW-1:0]      block_in,
    output logic                         in_ready,
    output logic                         ss_valid_in,
    output logic [CHW-1:0]               ss_ch,
    output logic [7:0][7:0][SW-1:0]      ss_block_in,
    input  logic [7:0][7:0][SW-1:0]      ss_block_1_out,
    input  logic [7:0][7:0][SW-1:0]      ss_block_2_out,
    input  logic [7:0][7:0][SW-1:0]      ss_block_3_out,
    input  logic [7:0][7:0][SW-1:0]      ss_block_4_out,
    input  logic [3:0]                   ss_valid_out,
    output logic                         out_valid,
    input  logic                         out_ready,
`ifdef GRAYSCALE_EN
    input  logic                         gray_mode,
`endif
    output logic [1:0]                   out_quad,
    output logic [7:0][7:0][SW-1:0]      y_out,
    output logic [7:0][7:0][SW-1:0]      cb_out,
    output logic [7:0][7:0][SW-1:0]      cr_out,
    output logic                         mcu_done,
    output logic                         seq_err
);

    typedef logic [7:0][7:0][SW-1:0] blk_t;
    typedef enum logic [1:0] {S_Y, S_CB, S_CR, S_EMIT} state_t;

    localparam logic [CHW-1:0] CH_Y  = CHW'(0);
    localparam logic [CHW-1:0] CH_CB = CHW'(1);
    localparam logic [CHW-1:0] CH_CR = CHW'(2);

    state_t         state_q, state_d;
    logic [1:0]     ycnt_q;
    logic [1:0]     quad_q;
    logic           seq_err_q;
    logic           mcu_done_q;
    logic [CHW-1:0] exp_ch;
    logic           chroma;
    logic           take_y;
    logic           take_c;
    logic           drop;
    logic           emit_hs;
    logic           last_y;
    logic           gray_go;

    blk_t ybuf  [4];
    blk_t cbbuf [4];
    blk_t crbuf [4];

`ifdef GRAYSCALE_EN
    logic gray_q;
    assign gray_go = gray_mode;
`else
    assign gray_go = 1'b0;
`endif

    // Decode acceptance, drop/error conditions and next state
    always_comb begin
        state_d     = state_q;
        exp_ch      = CH_Y;
        in_ready    = 1'b1;
        chroma      = 1'b0;
        case (state_q)
            S_Y:     exp_ch = CH_Y;
            S_CB:    begin exp_ch = CH_CB; chroma = 1'b1; end
            S_CR:    begin exp_ch = CH_CR; chroma = 1'b1; end
            default: in_ready = 1'b0;
        endcase

        take_y  = in_valid && in_ready && (state_q == S_Y) && (in_ch == exp_ch);
        // A chroma block only counts when all four upsampled quadrants are valid
        take_c  = in_valid && in_ready && chroma && (in_ch == exp_ch) && (ss_valid_out == 4'b1111);
        drop    = in_valid && in_ready && !take_y && !take_c;
        emit_hs = (state_q == S_EMIT) && out_ready;
        last_y  = take_y && (ycnt_q == 2'd3);

        case (state_q)
            S_Y:     if (last_y) state_d = gray_go ? S_EMIT : S_CB;
            S_CB:    if (take_c) state_d = S_CR;
            S_CR:    if (take_c) state_d = S_EMIT;
            default: if (emit_hs && (quad_q == 2'd3)) state_d = S_Y;
        endcase

        ss_valid_in = in_valid && chroma && (in_ch == exp_ch);
    end

    // Control state: FSM, Y counter, quadrant index and status pulses
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_Y;
            ycnt_q     <= 2'd0;
            quad_q     <= 2'd0;
            seq_err_q  <= 1'b0;
            mcu_done_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            seq_err_q  <= drop;
            mcu_done_q <= emit_hs && (quad_q == 2'd3);
            if (take_y)  ycnt_q <= ycnt_q + 2'd1;
            if (emit_hs) quad_q <= quad_q + 2'd1;
        end
    end

`ifdef GRAYSCALE_EN
    // Grayscale choice is latched with the last Y block of the MCU
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)    gray_q <= 1'b0;
        else if (last_y) gray_q <= gray_mode;
    end
`endif

    // Sample buffers are data-only and deliberately not reset
    always_ff @(posedge clock) begin
        if (take_y) ybuf[ycnt_q] <= block_in;
        if (take_c && (state_q == S_CB)) begin
            cbbuf[0] <= ss_block_1_out;
            cbbuf[1] <= ss_block_2_out;
            cbbuf[2] <= ss_block_3_out;
            cbbuf[3] <= ss_block_4_out;
        end
        if (take_c && (state_q == S_CR)) begin
            crbuf[0] <= ss_block_1_out;
            crbuf[1] <= ss_block_2_out;
            crbuf[2] <= ss_block_3_out;
            crbuf[3] <= ss_block_4_out;
        end
    end

    assign ss_ch       = in_ch;
    assign ss_block_in = block_in;
    assign out_valid   = (state_q == S_EMIT);
    assign out_quad    = quad_q;
    assign y_out       = ybuf[quad_q];
`ifdef GRAYSCALE_EN
    assign cb_out      = gray_q ? {64{SW'(128)}} : cbbuf[quad_q];
    assign cr_out      = gray_q ? {64{SW'(128)}} : crbuf[quad_q];
`else
    assign cb_out      = cbbuf[quad_q];
    assign cr_out      = crbuf[quad_q];
`endif
    assign mcu_done    = mcu_done_q;
    assign seq_err     = seq_err_q;

endmodule

// File: tb/tb_mcu_420_scheduler.sv
module tb_mcu_420_scheduler;

    typedef logic [7:0][7:0][8:0] blk_t;

    typedef struct {
        bit         iv;
        int         ch;
        int         val;
        bit         ordy;
        logic [3:0] ssv;
        bit         gm;
        bit         e_ov;
        bit         e_ir;
        bit         e_ssv;
        bit         e_err;
        bit         e_done;
        int         e_q;
        int         e_y;
        int         e_cb;
        int         e_cr;
    } vec_t;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in_ch = 2'd0;
    blk_t       block_in;
    logic       in_ready;
    logic       ss_valid_in;
    logic [1:0] ss_ch;
    blk_t       ss_block_in;
    blk_t       ss_b1, ss_b2, ss_b3, ss_b4;
    logic [3:0] ss_valid_out = 4'b1111;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [1:0] out_quad;
    blk_t       y_out, cb_out, cr_out;
    logic       mcu_done;
    logic       seq_err;
`ifdef GRAYSCALE_EN
    logic       gray_mode = 1'b0;
`endif

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    mcu_420_scheduler dut (
        .clock(clock), .reset_n(reset_n),
        .in_valid(in_valid), .in_ch(in_ch), .block_in(block_in), .in_ready(in_ready),
        .ss_valid_in(ss_valid_in), .ss_ch(ss_ch), .ss_block_in(ss_block_in),
        .ss_block_1_out(ss_b1), .ss_block_2_out(ss_b2),
        .ss_block_3_out(ss_b3), .ss_block_4_out(ss_b4),
        .ss_valid_out(ss_valid_out),
        .out_valid(out_valid), .out_ready(out_ready),
`ifdef GRAYSCALE_EN
        .gray_mode(gray_mode),
`endif
        .out_quad(out_quad), .y_out(y_out), .cb_out(cb_out), .cr_out(cr_out),
        .mcu_done(mcu_done), .seq_err(seq_err)
    );

    function automatic blk_t fill(input int v);
        blk_t b;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                b[i][j] = 9'(v);
        return b;
    endfunction

    // Stub supersampler: Cb quadrants are filled with 1..4, Cr quadrants with 5..8
    always_comb begin
        ss_b1 = fill((ss_ch == 2'd2) ? 5 : 1);
        ss_b2 = fill((ss_ch == 2'd2) ? 6 : 2);
        ss_b3 = fill((ss_ch == 2'd2) ? 7 : 3);
        ss_b4 = fill((ss_ch == 2'd2) ? 8 : 4);
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_blk(input string nm, input blk_t act, input int v);
        n_cmp++;
        if (act !== fill(v)) begin
            n_fail++;
            $display("FAIL %s: got [0][0]=%0d [7][7]=%0d, want all %0d (t=%0t)",
                     nm, act[0][0], act[7][7], v, $time);
        end
    endtask

    function automatic vec_t vin(input int ch, input int val, input logic [3:0] ssv,
                                 input bit essv, input bit eerr);
        vec_t v = '{default: 0};
        v.iv = 1; v.ch = ch; v.val = val; v.ordy = 1; v.ssv = ssv;
        v.e_ir = 1; v.e_ssv = essv; v.e_err = eerr;
        return v;
    endfunction

    function automatic vec_t vem(input bit ordy, input int q, input int y, input int cb, input int cr);
        vec_t v = '{default: 0};
        v.ordy = ordy; v.ssv = 4'b1111;
        v.e_ov = 1; v.e_q = q; v.e_y = y; v.e_cb = cb; v.e_cr = cr;
        return v;
    endfunction

    function automatic vec_t vidle(input bit edone);
        vec_t v = '{default: 0};
        v.ordy = 1; v.ssv = 4'b1111; v.e_ir = 1; v.e_done = edone;
        return v;
    endfunction

    // Apply one vector at the falling edge, check just after, then move to the next falling edge
    task automatic step(input vec_t v);
        in_valid     = v.iv;
        in_ch        = 2'(v.ch);
        block_in     = fill(v.val);
        out_ready    = v.ordy;
        ss_valid_out = v.ssv;
`ifdef GRAYSCALE_EN
        gray_mode    = v.gm;
`endif
        #1;
        chk("out_valid", int'(out_valid), int'(v.e_ov));
        chk("in_ready", int'(in_ready), int'(v.e_ir));
        chk("ss_valid_in", int'(ss_valid_in), int'(v.e_ssv));
        chk("seq_err", int'(seq_err), int'(v.e_err));
        chk("mcu_done", int'(mcu_done), int'(v.e_done));
        if (v.e_ov) begin
            chk("out_quad", int'(out_quad), v.e_q);
            chk_blk("y_out", y_out, v.e_y);
            chk_blk("cb_out", cb_out, v.e_cb);
            chk_blk("cr_out", cr_out, v.e_cr);
        end
        @(negedge clock);
    endtask

    task automatic pulse_reset(input int ch);
        in_valid     = 1'b1;
        in_ch        = 2'(ch);
        ss_valid_out = 4'b1111;
        reset_n      = 1'b0;
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_quad", int'(out_quad), 0);
        chk("rst_ss_valid_in", int'(ss_valid_in), 0);
        in_valid = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic nominal_mcu(input int y0, input int y1, input int y2, input int y3);
        step(vin(0, y0, 4'b1111, 0, 0));
        step(vin(0, y1, 4'b1111, 0, 0));
        step(vin(0, y2, 4'b1111, 0, 0));
        step(vin(0, y3, 4'b1111, 0, 0));
        step(vin(1, 200, 4'b1111, 1, 0));
        step(vin(2, 201, 4'b1111, 1, 0));
        step(vem(1, 0, y0, 1, 5));
        step(vem(1, 1, y1, 2, 6));
        step(vem(1, 2, y2, 3, 7));
        step(vem(1, 3, y3, 4, 8));
        step(vidle(1));
    endtask

    initial begin
        vec_t tbl[$];
        vec_t g;

        // Nominal MCU
        tbl.push_back(vin(0, 10, 4'b1111, 0, 0));
        tbl.push_back(vin(0, 20, 4'b1111, 0, 0));
        tbl.push_back(vin(0, 30, 4'b1111, 0, 0));
        tbl.push_back(vin(0, 40, 4'b1111, 0, 0));
        tbl.push_back(vin(1, 99, 4'b1111, 1, 0));
        tbl.push_back(vin(2, 98, 4'b1111, 1, 0));
        tbl.push_back(vem(1, 0, 10, 1, 5));
        tbl.push_back(vem(1, 1, 20, 2, 6));
        tbl.push_back(vem(1, 2, 30, 3, 7));
        tbl.push_back(vem(1, 3, 40, 4, 8));
        tbl.push_back(vidle(1));
        tbl.push_back(vidle(0));
        // Cb after only two Y blocks: dropped, error pulse, Y count preserved
        tbl.push_back(vin(0, 11, 4'b1111, 0, 0));
        tbl.push_back(vin(0, 12, 4'b1111, 0, 0));
        tbl.push_back(vin(1, 97, 4'b1111, 0, 0));
        tbl.push_back(vin(0, 13, 4'b1111, 0, 1));
        tbl.push_back(vin(0, 14, 4'b1111, 0, 0));
        // Supersampler fault on Cb, then retry
        tbl.push_back(vin(1, 96, 4'b0111, 1, 0));
        tbl.push_back(vin(1, 96, 4'b1111, 1, 1));
        // Y block while Cr expected: dropped, must not touch the Y buffer
        tbl.push_back(vin(0, 77, 4'b1111, 0, 0));
        tbl.push_back(vin(2, 95, 4'b1111, 1, 1));
        // Emit with 5 cycles of backpressure on quad 1
        tbl.push_back(vem(1, 0, 11, 1, 5));
        for (int i = 0; i < 5; i++) tbl.push_back(vem(0, 1, 12, 2, 6));
        tbl.push_back(vem(1, 1, 12, 2, 6));
        tbl.push_back(vem(1, 2, 13, 3, 7));
        tbl.push_back(vem(1, 3, 14, 4, 8));
        tbl.push_back(vidle(1));

        // Reset state
        block_in = fill(0);
        #1;
        chk("init_out_valid", int'(out_valid), 0);
        chk("init_in_ready", int'(in_ready), 1);
        chk("init_out_quad", int'(out_quad), 0);
        chk("init_mcu_done", int'(mcu_done), 0);
        chk("init_seq_err", int'(seq_err), 0);
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

        // Asynchronous reset while waiting for Cr
        step(vin(0, 50, 4'b1111, 0, 0));
        step(vin(0, 60, 4'b1111, 0, 0));
        step(vin(0, 70, 4'b1111, 0, 0));
        step(vin(0, 80, 4'b1111, 0, 0));
        step(vin(1, 90, 4'b1111, 1, 0));
        pulse_reset(2);
        step(vin(0, 91, 4'b1111, 0, 0));
        step(vin(0, 92, 4'b1111, 0, 0));
        step(vin(0, 93, 4'b1111, 0, 0));
        step(vin(0, 94, 4'b1111, 0, 0));
        step(vin(1, 90, 4'b1111, 1, 0));
        step(vin(2, 90, 4'b1111, 1, 0));
        step(vem(1, 0, 91, 1, 5));
        step(vem(1, 1, 92, 2, 6));
        // Asynchronous reset in the middle of emission
        pulse_reset(0);
        nominal_mcu(21, 22, 23, 24);

`ifdef GRAYSCALE_EN
        step(vin(0, 31, 4'b1111, 0, 0));
        step(vin(0, 32, 4'b1111, 0, 0));
        step(vin(0, 33, 4'b1111, 0, 0));
        g = vin(0, 34, 4'b1111, 0, 0);
        g.gm = 1;
        step(g);
        step(vem(1, 0, 31, 128, 128));
        step(vem(1, 1, 32, 128, 128));
        step(vem(1, 2, 33, 128, 128));
        step(vem(1, 3, 34, 128, 128));
        step(vidle(1));
        nominal_mcu(41, 42, 43, 44);
`else
        g = vidle(0);
        step(g);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
